// File: rtl/serial_add_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_driver_pkg
// Description : Shared state encoding, default sizes and helpers for the
//               serial adder driver.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_driver_pkg;

  localparam int DEFAULT_WIDTH   = 128;
  localparam int DEFAULT_TIMEOUT = 512;
  localparam int CNT_WIDTH       = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    RESP     = 2'd3
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_driver.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_driver
// Description : Accepts a host operand pair, pushes each operand to a serial
//               adder on its own channel, checks the returned sum against an
//               internally computed difference and reports the result (or a
//               timeout) back to the host, keeping transaction/error counts.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_driver
  import serial_add_driver_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 asyn_reset,
  input  logic                 host_vld,
  output logic                 host_rdy,
  input  logic [WIDTH-1:0]     host_x,
  input  logic [WIDTH-1:0]     host_y,
  output logic [WIDTH-1:0]     x,
  output logic [WIDTH-1:0]     y,
  output logic                 data_x_vld,
  input  logic                 data_x_rdy,
  output logic                 data_y_vld,
  input  logic                 data_y_rdy,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 cout,
  input  logic                 d_out_vld,
  output logic                 d_out_rdy,
  output logic [WIDTH-1:0]     res_sum,
  output logic                 res_cout,
  output logic                 res_err,
  output logic                 res_timeout,
  output logic                 res_vld,
  input  logic                 res_rdy,
  output logic [CNT_WIDTH-1:0] txn_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int            TW        = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic                 host_rdy_q, host_rdy_d;
  logic [WIDTH-1:0]     x_q, x_d, y_q, y_d, exp_q, exp_d;
  logic                 x_done_q, x_done_d, y_done_q, y_done_d;
  logic                 data_x_vld_q, data_x_vld_d, data_y_vld_q, data_y_vld_d;
  logic                 d_out_rdy_q, d_out_rdy_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [WIDTH-1:0]     res_sum_q, res_sum_d;
  logic                 res_cout_q, res_cout_d, res_err_q, res_err_d;
  logic                 res_timeout_q, res_timeout_d, res_vld_q, res_vld_d;
  logic [CNT_WIDTH-1:0] txn_cnt_q, txn_cnt_d, err_cnt_q, err_cnt_d;

  // Next-state and next-output computation for the whole transaction FSM.
  always_comb begin
    state_d       = state_q;
    host_rdy_d    = host_rdy_q;
    x_d           = x_q;
    y_d           = y_q;
    exp_d         = exp_q;
    x_done_d      = x_done_q;
    y_done_d      = y_done_q;
    data_x_vld_d  = data_x_vld_q;
    data_y_vld_d  = data_y_vld_q;
    d_out_rdy_d   = d_out_rdy_q;
    timer_d       = timer_q;
    res_sum_d     = res_sum_q;
    res_cout_d    = res_cout_q;
    res_err_d     = res_err_q;
    res_timeout_d = res_timeout_q;
    res_vld_d     = res_vld_q;
    txn_cnt_d     = txn_cnt_q;
    err_cnt_d     = err_cnt_q;

    case (state_q)
      IDLE: begin
        host_rdy_d = 1'b1;
        if (host_vld && host_rdy_q) begin
          host_rdy_d   = 1'b0;
          x_d          = host_x;
          y_d          = host_y;
          exp_d        = host_x - host_y;
          x_done_d     = 1'b0;
          y_done_d     = 1'b0;
          timer_d      = '0;
          data_x_vld_d = 1'b1;
          data_y_vld_d = 1'b1;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        timer_d = timer_q + TW'(1);
        if (data_x_vld_q && data_x_rdy) begin
          x_done_d     = 1'b1;
          data_x_vld_d = 1'b0;
        end
        if (data_y_vld_q && data_y_rdy) begin
          y_done_d     = 1'b1;
          data_y_vld_d = 1'b0;
        end
        if (x_done_d && y_done_d) begin
          d_out_rdy_d = 1'b1;
          state_d     = WAIT_RES;
        end
        // Expiry overrides channel progress: there is nothing to capture yet.
        if (timer_q == TIMER_END) begin
          data_x_vld_d  = 1'b0;
          data_y_vld_d  = 1'b0;
          d_out_rdy_d   = 1'b0;
          res_sum_d     = '0;
          res_cout_d    = 1'b0;
          res_err_d     = 1'b0;
          res_timeout_d = 1'b1;
          res_vld_d     = 1'b1;
          state_d       = RESP;
        end
      end

      WAIT_RES: begin
        timer_d = timer_q + TW'(1);
        // A result arriving on the expiry cycle is still taken.
        if (d_out_vld && d_out_rdy_q) begin
          d_out_rdy_d   = 1'b0;
          res_sum_d     = sum;
          res_cout_d    = cout;
          res_err_d     = (sum != exp_q);
          res_timeout_d = 1'b0;
          res_vld_d     = 1'b1;
          state_d       = RESP;
        end else if (timer_q == TIMER_END) begin
          d_out_rdy_d   = 1'b0;
          res_sum_d     = '0;
          res_cout_d    = 1'b0;
          res_err_d     = 1'b0;
          res_timeout_d = 1'b1;
          res_vld_d     = 1'b1;
          state_d       = RESP;
        end
      end

      RESP: begin
        if (res_vld_q && res_rdy) begin
          res_vld_d  = 1'b0;
          host_rdy_d = 1'b1;
          txn_cnt_d  = sat_inc(txn_cnt_q);
          if (res_err_q || res_timeout_q) begin
            err_cnt_d = sat_inc(err_cnt_q);
          end
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any transaction in flight.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q       <= IDLE;
      host_rdy_q    <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      exp_q         <= '0;
      x_done_q      <= 1'b0;
      y_done_q      <= 1'b0;
      data_x_vld_q  <= 1'b0;
      data_y_vld_q  <= 1'b0;
      d_out_rdy_q   <= 1'b0;
      timer_q       <= '0;
      res_sum_q     <= '0;
      res_cout_q    <= 1'b0;
      res_err_q     <= 1'b0;
      res_timeout_q <= 1'b0;
      res_vld_q     <= 1'b0;
      txn_cnt_q     <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      host_rdy_q    <= host_rdy_d;
      x_q           <= x_d;
      y_q           <= y_d;
      exp_q         <= exp_d;
      x_done_q      <= x_done_d;
      y_done_q      <= y_done_d;
      data_x_vld_q  <= data_x_vld_d;
      data_y_vld_q  <= data_y_vld_d;
      d_out_rdy_q   <= d_out_rdy_d;
      timer_q       <= timer_d;
      res_sum_q     <= res_sum_d;
      res_cout_q    <= res_cout_d;
      res_err_q     <= res_err_d;
      res_timeout_q <= res_timeout_d;
      res_vld_q     <= res_vld_d;
      txn_cnt_q     <= txn_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign host_rdy    = host_rdy_q;
  assign x           = x_q;
  assign y           = y_q;
  assign data_x_vld  = data_x_vld_q;
  assign data_y_vld  = data_y_vld_q;
  assign d_out_rdy   = d_out_rdy_q;
  assign res_sum     = res_sum_q;
  assign res_cout    = res_cout_q;
  assign res_err     = res_err_q;
  assign res_timeout = res_timeout_q;
  assign res_vld     = res_vld_q;
  assign txn_cnt     = txn_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_driver
// Description : Directed self-checking bench for serial_add_driver, with the
//               serial adder replaced by stimulus driven from tasks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_driver;

  localparam int W = 128;

  logic          clk = 1'b0;
  logic          asyn_reset;
  logic          host_vld, host_rdy;
  logic [W-1:0]  host_x, host_y, x, y, sum, res_sum;
  logic          data_x_vld, data_x_rdy, data_y_vld, data_y_rdy;
  logic          cout, d_out_vld, d_out_rdy;
  logic          res_cout, res_err, res_timeout, res_vld, res_rdy;
  logic [15:0]   txn_cnt, err_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_add_driver #(.WIDTH(W), .TIMEOUT(512)) dut (
    .clk(clk), .asyn_reset(asyn_reset),
    .host_vld(host_vld), .host_rdy(host_rdy), .host_x(host_x), .host_y(host_y),
    .x(x), .y(y),
    .data_x_vld(data_x_vld), .data_x_rdy(data_x_rdy),
    .data_y_vld(data_y_vld), .data_y_rdy(data_y_rdy),
    .sum(sum), .cout(cout), .d_out_vld(d_out_vld), .d_out_rdy(d_out_rdy),
    .res_sum(res_sum), .res_cout(res_cout), .res_err(res_err),
    .res_timeout(res_timeout), .res_vld(res_vld), .res_rdy(res_rdy),
    .txn_cnt(txn_cnt), .err_cnt(err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair once host_rdy is up; returns in the ISSUE entry cycle.
  task automatic send_host(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (host_rdy !== 1'b1 && n < 50) begin tick(); n++; end
    if (host_rdy !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_host_wait: host_rdy=%b required 1", host_rdy);
    end
    host_x = a; host_y = b; host_vld = 1'b1;
    tick();
    host_vld = 1'b0;
  endtask

  // Accept both operand channels in the same cycle.
  task automatic serve_channels();
    data_x_rdy = 1'b1; data_y_rdy = 1'b1;
    tick();
    data_x_rdy = 1'b0; data_y_rdy = 1'b0;
  endtask

  // Stub adder output: wait for d_out_rdy then present one result beat.
  task automatic adder_respond(input logic [W-1:0] s, input logic c);
    int n = 0;
    while (d_out_rdy !== 1'b1 && n < 50) begin tick(); n++; end
    if (d_out_rdy !== 1'b1) begin
      checks++; errors++;
      $display("FAIL adder_wait: d_out_rdy=%b required 1", d_out_rdy);
    end
    d_out_vld = 1'b1; sum = s; cout = c;
    tick();
    d_out_vld = 1'b0;
  endtask

  task automatic host_accept();
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
  endtask

  task automatic test_reset();
    asyn_reset = 1'b1;
    host_vld = 1'b0; host_x = '0; host_y = '0;
    data_x_rdy = 1'b0; data_y_rdy = 1'b0;
    sum = '0; cout = 1'b0; d_out_vld = 1'b0; res_rdy = 1'b0;
    #3;
    checks++; if (host_rdy !== 1'b0) begin errors++; $display("FAIL reset_host_rdy: got %b required 0", host_rdy); end
    checks++; if ({data_x_vld, data_y_vld, d_out_rdy, res_vld} !== 4'b0) begin errors++; $display("FAIL reset_vld_rdy: got %b required 0000", {data_x_vld, data_y_vld, d_out_rdy, res_vld}); end
    checks++; if (txn_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters: txn=%0d err=%0d required 0/0", txn_cnt, err_cnt); end
    checks++; if (x !== '0 || y !== '0 || res_sum !== '0) begin errors++; $display("FAIL reset_data: x=%0h y=%0h res_sum=%0h required 0", x, y, res_sum); end
    tick(); tick();
    asyn_reset = 1'b0;
    checks++; if (host_rdy !== 1'b0) begin errors++; $display("FAIL reset_release_rdy: got %b required 0", host_rdy); end
    tick();
    checks++; if (host_rdy !== 1'b1) begin errors++; $display("FAIL reset_first_edge_rdy: got %b required 1", host_rdy); end
  endtask

  task automatic test_basic();
    send_host(128'd10, 128'd3);
    checks++; if (x !== 128'd10 || y !== 128'd3) begin errors++; $display("FAIL basic_operands: x=%0d y=%0d required 10/3", x, y); end
    checks++; if ({data_x_vld, data_y_vld, host_rdy} !== 3'b110) begin errors++; $display("FAIL basic_issue: got %b required 110", {data_x_vld, data_y_vld, host_rdy}); end
    serve_channels();
    checks++; if ({data_x_vld, data_y_vld, d_out_rdy} !== 3'b001) begin errors++; $display("FAIL basic_wait_res: got %b required 001", {data_x_vld, data_y_vld, d_out_rdy}); end
    adder_respond(128'd7, 1'b1);
    checks++; if (res_vld !== 1'b1 || res_sum !== 128'd7) begin errors++; $display("FAIL basic_result: vld=%b sum=%0d required 1/7", res_vld, res_sum); end
    checks++; if ({res_cout, res_err, res_timeout, d_out_rdy} !== 4'b1000) begin errors++; $display("FAIL basic_flags: got %b required 1000", {res_cout, res_err, res_timeout, d_out_rdy}); end
    host_accept();
    checks++; if (txn_cnt !== 16'd1 || err_cnt !== 16'd0) begin errors++; $display("FAIL basic_counts: txn=%0d err=%0d required 1/0", txn_cnt, err_cnt); end
    checks++; if (res_vld !== 1'b0 || host_rdy !== 1'b1) begin errors++; $display("FAIL basic_idle: vld=%b rdy=%b required 0/1", res_vld, host_rdy); end
  endtask

  task automatic test_negative();
    logic [W-1:0] e;
    e = '1;
    e = e - 128'd6;            // 2^128 - 7
    send_host(128'd3, 128'd10);
    serve_channels();
    adder_respond(e, 1'b0);
    checks++; if (res_sum !== e || res_err !== 1'b0) begin errors++; $display("FAIL negative_result: sum=%0h err=%b required %0h/0", res_sum, res_err, e); end
    host_accept();
    checks++; if (txn_cnt !== 16'd2 || err_cnt !== 16'd0) begin errors++; $display("FAIL negative_counts: txn=%0d err=%0d required 2/0", txn_cnt, err_cnt); end
  endtask

  task automatic test_split_channels();
    send_host(128'd100, 128'd40);
    data_x_rdy = 1'b1;
    tick();
    data_x_rdy = 1'b0;
    checks++; if ({data_x_vld, data_y_vld, d_out_rdy} !== 3'b010) begin errors++; $display("FAIL split_x_done: got %b required 010", {data_x_vld, data_y_vld, d_out_rdy}); end
    for (int i = 1; i < 5; i++) begin
      tick();
      checks++; if ({data_x_vld, data_y_vld, d_out_rdy} !== 3'b010) begin errors++; $display("FAIL split_hold[%0d]: got %b required 010", i, {data_x_vld, data_y_vld, d_out_rdy}); end
    end
    checks++; if (x !== 128'd100 || y !== 128'd40) begin errors++; $display("FAIL split_stable: x=%0d y=%0d required 100/40", x, y); end
    data_y_rdy = 1'b1;
    tick();
    data_y_rdy = 1'b0;
    checks++; if ({data_x_vld, data_y_vld, d_out_rdy} !== 3'b001) begin errors++; $display("FAIL split_y_done: got %b required 001", {data_x_vld, data_y_vld, d_out_rdy}); end
    tick(); tick();
    checks++; if (d_out_rdy !== 1'b1 || res_vld !== 1'b0) begin errors++; $display("FAIL split_single_wait: rdy=%b vld=%b required 1/0", d_out_rdy, res_vld); end
    adder_respond(128'd60, 1'b1);
    checks++; if (res_sum !== 128'd60 || res_err !== 1'b0) begin errors++; $display("FAIL split_result: sum=%0d err=%b required 60/0", res_sum, res_err); end
    host_accept();
    checks++; if (txn_cnt !== 16'd3) begin errors++; $display("FAIL split_count: txn=%0d required 3", txn_cnt); end
  endtask

  task automatic test_error();
    send_host(128'd5, 128'd2);
    serve_channels();
    adder_respond(128'd2, 1'b1);    // expected 3, flip bit 0
    checks++; if (res_err !== 1'b1 || res_sum !== 128'd2 || res_timeout !== 1'b0) begin errors++; $display("FAIL error_flag: err=%b sum=%0d to=%b required 1/2/0", res_err, res_sum, res_timeout); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL error_early_count: err=%0d required 0", err_cnt); end
    host_accept();
    checks++; if (err_cnt !== 16'd1 || txn_cnt !== 16'd4) begin errors++; $display("FAIL error_counts: txn=%0d err=%0d required 4/1", txn_cnt, err_cnt); end
  endtask

  task automatic test_timeout();
    int n;
    send_host(128'd20, 128'd1);
    serve_channels();
    n = 1;
    while (res_vld !== 1'b1 && n < 700) begin tick(); n++; end
    checks++; if (n != 512) begin errors++; $display("FAIL timeout_latency: res_vld after %0d cycles required 512", n); end
    checks++; if ({res_timeout, res_err, res_cout} !== 3'b100 || res_sum !== '0) begin errors++; $display("FAIL timeout_payload: to/err/cout=%b sum=%0h required 100/0", {res_timeout, res_err, res_cout}, res_sum); end
    checks++; if ({data_x_vld, data_y_vld, d_out_rdy} !== 3'b000) begin errors++; $display("FAIL timeout_drop: got %b required 000", {data_x_vld, data_y_vld, d_out_rdy}); end
    host_accept();
    checks++; if (err_cnt !== 16'd2 || txn_cnt !== 16'd5) begin errors++; $display("FAIL timeout_counts: txn=%0d err=%0d required 5/2", txn_cnt, err_cnt); end
  endtask

  task automatic test_stall();
    send_host(128'd9, 128'd4);
    serve_channels();
    adder_respond(128'd5, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checks++; if (res_vld !== 1'b1 || res_sum !== 128'd5 || txn_cnt !== 16'd5) begin errors++; $display("FAIL stall_hold[%0d]: vld=%b sum=%0d txn=%0d required 1/5/5", i, res_vld, res_sum, txn_cnt); end
      tick();
    end
    host_accept();
    checks++; if (txn_cnt !== 16'd6 || err_cnt !== 16'd2) begin errors++; $display("FAIL stall_counts: txn=%0d err=%0d required 6/2", txn_cnt, err_cnt); end
  endtask

  task automatic test_ignore_dout();
    d_out_vld = 1'b1; sum = 128'd123;
    tick(); tick(); tick();
    d_out_vld = 1'b0;
    checks++; if (res_vld !== 1'b0 || host_rdy !== 1'b1 || d_out_rdy !== 1'b0) begin errors++; $display("FAIL ignore_dout: vld=%b host_rdy=%b d_out_rdy=%b required 0/1/0", res_vld, host_rdy, d_out_rdy); end
  endtask

  task automatic test_reset_mid();
    send_host(128'd1, 128'd1);
    serve_channels();
    checks++; if (d_out_rdy !== 1'b1) begin errors++; $display("FAIL midrst_in_wait: d_out_rdy=%b required 1", d_out_rdy); end
    #2 asyn_reset = 1'b1;
    #1;
    checks++; if ({d_out_rdy, res_vld, host_rdy} !== 3'b000) begin errors++; $display("FAIL midrst_outputs: got %b required 000", {d_out_rdy, res_vld, host_rdy}); end
    checks++; if (txn_cnt !== 16'd0 || err_cnt !== 16'd0 || x !== '0) begin errors++; $display("FAIL midrst_clear: txn=%0d err=%0d x=%0d required 0/0/0", txn_cnt, err_cnt, x); end
    tick();
    asyn_reset = 1'b0;
    tick();
    checks++; if (host_rdy !== 1'b1 || txn_cnt !== 16'd0) begin errors++; $display("FAIL midrst_recover: rdy=%b txn=%0d required 1/0", host_rdy, txn_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    e = '0;
    e = e - 128'd42;
    send_host(128'd50, 128'd8);
    serve_channels();
    adder_respond(128'd42, 1'b1);
    checks++; if (res_sum !== 128'd42 || res_err !== 1'b0) begin errors++; $display("FAIL b2b_first: sum=%0d err=%b required 42/0", res_sum, res_err); end
    host_accept();
    send_host(128'd8, 128'd50);
    serve_channels();
    adder_respond(e, 1'b0);
    checks++; if (res_sum !== e || res_err !== 1'b0) begin errors++; $display("FAIL b2b_second: sum=%0h err=%b required %0h/0", res_sum, res_err, e); end
    host_accept();
    checks++; if (txn_cnt !== 16'd2 || err_cnt !== 16'd0) begin errors++; $display("FAIL b2b_counts: txn=%0d err=%0d required 2/0", txn_cnt, err_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_split_channels();
    test_error();
    test_timeout();
    test_stall();
    test_ignore_dout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
